// File: rtl/csr_issue_arbiter.sv
// csr_issue_arbiter: shares the single-entry CSR buffer among the issue lanes in program order
module csr_issue_arbiter #(
   parameter int unsigned NR_LANES      = 4,
   parameter int unsigned STALL_CNT_W   = 16,
   parameter int unsigned TRANS_ID_BITS = 3
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              flush_i,
   input  logic [NR_LANES-1:0]               lane_valid_i,
   input  logic [NR_LANES*64-1:0]            lane_operand_a_i,
   input  logic [NR_LANES*64-1:0]            lane_operand_b_i,
   input  logic [NR_LANES*TRANS_ID_BITS-1:0] lane_trans_id_i,
   output logic [NR_LANES-1:0]               lane_ready_o,
   output logic                              buf_valid_o,
   output logic [63:0]                       buf_operand_a_o,
   output logic [63:0]                       buf_operand_b_o,
   output logic [TRANS_ID_BITS-1:0]          buf_trans_id_o,
   input  logic                              buf_ready_i,
   input  logic                              commit_i,
   output logic                              buf_commit_o,
   output logic                              pending_o,
   output logic [STALL_CNT_W-1:0]            stall_cnt_o,
   output logic                              err_o
);
   localparam int unsigned SEL_W = NR_LANES > 1 ? $clog2(NR_LANES) : 1;
   typedef enum logic {IDLE, BUSY} state_e;
   state_e                 state_q;
   logic                   pending_q;
   logic                   err_q;
   logic [STALL_CNT_W-1:0] stall_cnt_q;
   logic [SEL_W-1:0]       sel;
   logic                   any_valid;
   logic                   can_issue;
   logic                   grant;
   assign any_valid    = |lane_valid_i;
   assign can_issue    = buf_ready_i & ~flush_i & (state_q == IDLE || commit_i);
   assign grant        = can_issue & any_valid;
   assign buf_valid_o  = grant;
   assign buf_commit_o = commit_i & (state_q == BUSY);
   assign pending_o    = pending_q;
   assign stall_cnt_o  = stall_cnt_q;
   assign err_o        = err_q;
   // pick the lowest-indexed valid lane (oldest op in program order)
   always_comb begin
      sel = '0;
      for (int i = NR_LANES - 1; i >= 0; i--)
         if (lane_valid_i[i]) sel = SEL_W'(i);
   end
   // a lane is ready only if no older lane is presenting an op, so at most one is taken
   always_comb begin
      logic blocked;
      blocked      = 1'b0;
      lane_ready_o = '0;
      for (int i = 0; i < NR_LANES; i++) begin
         lane_ready_o[i] = can_issue & ~blocked;
         blocked         = blocked | lane_valid_i[i];
      end
   end
   // forward the selected lane's payload, zeroed when no lane is valid
   always_comb begin
      buf_operand_a_o = any_valid ? lane_operand_a_i[int'(sel)*64 +: 64] : '0;
      buf_operand_b_o = any_valid ? lane_operand_b_i[int'(sel)*64 +: 64] : '0;
      buf_trans_id_o  = any_valid ? lane_trans_id_i[int'(sel)*TRANS_ID_BITS +: TRANS_ID_BITS] : '0;
   end
   // occupancy FSM plus saturating stall counter and sticky stray-commit flag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         pending_q   <= 1'b0;
         stall_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         if (flush_i) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
         end else if (grant) begin
            state_q   <= BUSY;
            pending_q <= 1'b1;
         end else if (state_q == BUSY && commit_i) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
         end
         if (commit_i && state_q == IDLE) err_q <= 1'b1;
         if (any_valid && !grant && !flush_i && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end
endmodule

// File: tb/tb_csr_issue_arbiter.sv
// tb_csr_issue_arbiter: scoreboard bench for the CSR issue arbiter
module tb_csr_issue_arbiter;
   localparam int NL = 4;
   localparam int TW = 3;
   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              flush_i;
   logic [NL-1:0]     lane_valid_i;
   logic [NL*64-1:0]  lane_operand_a_i;
   logic [NL*64-1:0]  lane_operand_b_i;
   logic [NL*TW-1:0]  lane_trans_id_i;
   logic [NL-1:0]     lane_ready_o;
   logic              buf_valid_o;
   logic [63:0]       buf_operand_a_o;
   logic [63:0]       buf_operand_b_o;
   logic [TW-1:0]     buf_trans_id_o;
   logic              buf_ready_i;
   logic              commit_i;
   logic              buf_commit_o;
   logic              pending_o;
   logic [15:0]       stall_cnt_o;
   logic              err_o;
   int n_tests = 0;
   int n_fail  = 0;
   logic [63:0] la [NL] = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
   logic [63:0] lb [NL] = '{64'h341, 64'h300, 64'h305, 64'h7C0};
   logic [TW-1:0] lid [NL] = '{3'd1, 3'd5, 3'd2, 3'd7};
   typedef struct {
      logic [NL-1:0] rdy;
      logic          vld;
      logic [63:0]   a;
      logic [63:0]   b;
      logic [TW-1:0] id;
      logic          cmt;
   } exp_t;
   exp_t exp_q[$];
   logic [15:0] exp_stall;
   csr_issue_arbiter #(.NR_LANES(NL), .STALL_CNT_W(16), .TRANS_ID_BITS(TW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .lane_valid_i(lane_valid_i), .lane_operand_a_i(lane_operand_a_i),
      .lane_operand_b_i(lane_operand_b_i), .lane_trans_id_i(lane_trans_id_i),
      .lane_ready_o(lane_ready_o), .buf_valid_o(buf_valid_o),
      .buf_operand_a_o(buf_operand_a_o), .buf_operand_b_o(buf_operand_b_o),
      .buf_trans_id_o(buf_trans_id_o), .buf_ready_i(buf_ready_i),
      .commit_i(commit_i), .buf_commit_o(buf_commit_o), .pending_o(pending_o),
      .stall_cnt_o(stall_cnt_o), .err_o(err_o)
   );
   always #5 clk_i = ~clk_i;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask
   // drive one cycle of stimulus and queue the expected combinational response
   task automatic drv(input logic [NL-1:0] v, input logic c, input logic f, input logic r,
                      input logic [NL-1:0] e_rdy, input logic e_vld, input int e_lane, input logic e_cmt);
      exp_t e;
      lane_valid_i = v;
      commit_i     = c;
      flush_i      = f;
      buf_ready_i  = r;
      e.rdy = e_rdy;
      e.vld = e_vld;
      e.a   = e_lane < 0 ? 64'h0 : la[e_lane];
      e.b   = e_lane < 0 ? 64'h0 : lb[e_lane];
      e.id  = e_lane < 0 ? '0 : lid[e_lane];
      e.cmt = e_cmt;
      exp_q.push_back(e);
   endtask
   // pop the oldest expectation and compare it with what the DUT presents
   task automatic smp(input string tag);
      exp_t e;
      #1;
      e = exp_q.pop_front();
      chk({tag, "_rdy"}, 64'(lane_ready_o), 64'(e.rdy));
      chk({tag, "_vld"}, 64'(buf_valid_o), 64'(e.vld));
      chk({tag, "_a"}, buf_operand_a_o, e.a);
      chk({tag, "_b"}, buf_operand_b_o, e.b);
      chk({tag, "_id"}, 64'(buf_trans_id_o), 64'(e.id));
      chk({tag, "_cmt"}, 64'(buf_commit_o), 64'(e.cmt));
   endtask
   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end
   initial begin
      for (int i = 0; i < NL; i++) begin
         lane_operand_a_i[i*64 +: 64] = la[i];
         lane_operand_b_i[i*64 +: 64] = lb[i];
         lane_trans_id_i[i*TW +: TW]  = lid[i];
      end
      rst_ni = 1'b0;
      lane_valid_i = '0;
      commit_i = 1'b0;
      flush_i = 1'b0;
      buf_ready_i = 1'b1;
      repeat (2) tick();
      rst_ni = 1'b1;
      // reset state, idle with nothing valid
      drv(4'b0000, 0, 0, 1, 4'b1111, 0, -1, 0); smp("t1");
      chk("t1_pend", 64'(pending_o), 0);
      chk("t1_stall", 64'(stall_cnt_o), 0);
      chk("t1_err", 64'(err_o), 0);
      tick();
      // lanes 1 and 3 valid: lane 1 wins
      drv(4'b1010, 0, 0, 1, 4'b0011, 1, 1, 0); smp("t2");
      tick();
      chk("t2_pend", 64'(pending_o), 1);
      // busy without commit: refused three times
      for (int k = 0; k < 3; k++) begin
         drv(4'b0001, 0, 0, 1, 4'b0000, 0, 0, 0); smp("t3_wait");
         tick();
      end
      chk("t3_stall", 64'(stall_cnt_o), 3);
      drv(4'b0001, 1, 0, 1, 4'b0001, 1, 0, 1); smp("t3_b2b");
      tick();
      chk("t3_pend", 64'(pending_o), 1);
      chk("t3_stall2", 64'(stall_cnt_o), 3);
      // flush while busy drops the op and blocks the grant
      drv(4'b0001, 0, 1, 1, 4'b0000, 0, 0, 0); smp("t4_flush");
      tick();
      chk("t4_pend", 64'(pending_o), 0);
      chk("t4_stall", 64'(stall_cnt_o), 3);
      drv(4'b0001, 0, 0, 1, 4'b0001, 1, 0, 0); smp("t4_regrant");
      tick();
      chk("t4_pend2", 64'(pending_o), 1);
      drv(4'b0000, 1, 0, 1, 4'b1111, 0, -1, 1); smp("t4_commit");
      tick();
      chk("t4_pend3", 64'(pending_o), 0);
      // stray commit in idle sets the sticky error
      drv(4'b0000, 1, 0, 1, 4'b1111, 0, -1, 0); smp("t5_stray");
      chk("t5_err0", 64'(err_o), 0);
      tick();
      chk("t5_err1", 64'(err_o), 1);
      drv(4'b0000, 0, 1, 1, 4'b0000, 0, -1, 0); smp("t5_flush");
      tick();
      chk("t5_err2", 64'(err_o), 1);
      chk("t5_pend", 64'(pending_o), 0);
      // buffer never ready: counter climbs to all-ones and sticks
      exp_stall = 16'd3;
      drv(4'b0100, 0, 0, 0, 4'b0000, 0, 2, 0); smp("t6_stall");
      for (int k = 0; k < 65538; k++) begin
         tick();
         exp_stall = (exp_stall == 16'hFFFF) ? 16'hFFFF : exp_stall + 16'd1;
         if (k == 65529) chk("t6_near", 64'(stall_cnt_o), 64'(exp_stall));
      end
      chk("t6_sat", 64'(stall_cnt_o), 64'hFFFF);
      chk("t6_model", 64'(stall_cnt_o), 64'(exp_stall));
      // asynchronous reset mid-operation
      drv(4'b0001, 0, 0, 1, 4'b0001, 1, 0, 0); smp("t7_grant");
      tick();
      chk("t7_pend", 64'(pending_o), 1);
      rst_ni = 1'b0;
      #1;
      chk("t7_rst_pend", 64'(pending_o), 0);
      chk("t7_rst_stall", 64'(stall_cnt_o), 0);
      chk("t7_rst_err", 64'(err_o), 0);
      tick();
      rst_ni = 1'b1;
      drv(4'b0000, 1, 0, 1, 4'b1111, 0, -1, 0); smp("t7_commit");
      tick();
      chk("t7_err", 64'(err_o), 1);
      chk("t7_pend2", 64'(pending_o), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
